// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD panel model and its controller.
package lcd_pkg;
    typedef enum logic [1:0] {
        POWERUP,
        IDLE,
        EXEC
    } lcd_state_e;

    typedef struct packed {
        logic disp_on;
        logic cursor_on;
        logic blink_on;
        logic inc_dec;
        logic shift;
        logic two_line;
        logic font;
    } lcd_mode_t;

    localparam int unsigned LCD_DDRAM_DEPTH = 80;
    localparam logic [7:0]  BLANK_CHAR      = 8'h20;

    // Instruction class is selected by the highest set bit of the byte.
    localparam int unsigned OP_SET_DDRAM = 7;
    localparam int unsigned OP_SET_CGRAM = 6;
    localparam int unsigned OP_FUNC_SET  = 5;
    localparam int unsigned OP_SHIFT     = 4;
    localparam int unsigned OP_DISP_CTRL = 3;
    localparam int unsigned OP_ENTRY     = 2;
    localparam int unsigned OP_HOME      = 1;
    localparam int unsigned OP_CLEAR     = 0;

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc,
                                           input logic [6:0] last);
        if (inc) return (a == last) ? 7'd0 : a + 7'd1;
        return (a == 7'd0) ? last : a - 7'd1;
    endfunction
endpackage

// File: rtl/lcd_ddram.sv
// Character DDRAM: one synchronous write port, two asynchronous read ports.
module lcd_ddram
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = LCD_DDRAM_DEPTH
) (
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [6:0] raddr_b,
    output logic [7:0] rdata_b
);
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Addresses beyond the populated cells read as zero.
    assign rdata_a = (32'(raddr_a) < DEPTH) ? mem_q[raddr_a] : '0;
    assign rdata_b = (32'(raddr_b) < DEPTH) ? mem_q[raddr_b] : '0;
endmodule

// File: rtl/lcd_responder.sv
// Device end of an HD44780-style parallel LCD bus: decodes accesses, keeps
// DDRAM/AC/mode state, models execution busy time and flags protocol errors.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 500,
    parameter int unsigned CMD_CYCLES     = 50,
    parameter int unsigned CLEAR_CYCLES   = 200,
    parameter int unsigned DDRAM_DEPTH    = LCD_DDRAM_DEPTH,
    parameter int unsigned CBITS          = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] lcd_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy_flag,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_dec,
    output logic       shift,
    output logic       two_line,
    output logic       font,
    output logic       init_done,
    output logic       proto_err,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_char
);
    localparam logic [6:0] AC_LAST = 7'(DDRAM_DEPTH - 1);

    lcd_state_e       state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic             e_q;
    logic [6:0]       ac_q, ac_d;
    logic [6:0]       fill_q, fill_d;
    logic             fill_active_q, fill_active_d;
    lcd_mode_t        mode_q, mode_d;
    logic             init_done_q, init_done_d;
    logic             proto_err_q, proto_err_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic       rise, fall, busy;
    logic       mem_we;
    logic [6:0] mem_waddr;
    logic [7:0] mem_wdata, ac_char;

    assign rise = e & ~e_q;
    assign fall = ~e & e_q;
    assign busy = (state_q != IDLE);

    // Write enable is gated by reset so a reset edge cannot land one more fill cell.
    lcd_ddram #(.DEPTH(DDRAM_DEPTH)) u_ddram (
        .clk     (clk),
        .we      (mem_we & ~rst),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (ac_q),
        .rdata_a (ac_char),
        .raddr_b (dbg_addr),
        .rdata_b (dbg_char)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ac_d          = ac_q;
        fill_d        = fill_q;
        fill_active_d = fill_active_q;
        mode_d        = mode_q;
        init_done_d   = init_done_q;
        proto_err_d   = proto_err_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = rd_valid_q;
        mem_we        = 1'b0;
        mem_waddr     = ac_q;
        mem_wdata     = lcd_data;

        unique case (state_q)
            POWERUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CBITS'(POWERUP_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CBITS'(1)) state_d = IDLE;
                if (fill_active_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = fill_q;
                    mem_wdata = BLANK_CHAR;
                    fill_d    = fill_q + 7'd1;
                    if (fill_q == AC_LAST) fill_active_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (rise && rw) begin
            rd_valid_d = 1'b1;
            if (!rs) begin
                rd_data_d = {busy, ac_q};
            end else if (!busy) begin
                rd_data_d = ac_char;
                ac_d      = ac_step(ac_q, mode_q.inc_dec, AC_LAST);
                state_d   = EXEC;
                cnt_d     = CBITS'(CMD_CYCLES);
            end else begin
                rd_data_d   = '0;
                proto_err_d = 1'b1;
            end
        end

        if (fall) begin
            rd_valid_d = 1'b0;
            if (!rw) begin
                if (busy) begin
                    proto_err_d = 1'b1;
                end else if (rs) begin
                    mem_we  = 1'b1;
                    ac_d    = ac_step(ac_q, mode_q.inc_dec, AC_LAST);
                    state_d = EXEC;
                    cnt_d   = CBITS'(CMD_CYCLES);
                end else begin
                    state_d = EXEC;
                    cnt_d   = CBITS'(CMD_CYCLES);
                    if (!init_done_q && lcd_data[7:5] != 3'b001) proto_err_d = 1'b1;
                    if (lcd_data[OP_SET_DDRAM]) begin
                        ac_d = 7'(32'(lcd_data[6:0]) % DDRAM_DEPTH);
                    end else if (lcd_data[OP_SET_CGRAM]) begin
                    end else if (lcd_data[OP_FUNC_SET]) begin
                        mode_d.two_line = lcd_data[3];
                        mode_d.font     = lcd_data[2];
                        init_done_d     = 1'b1;
                    end else if (lcd_data[OP_SHIFT]) begin
                    end else if (lcd_data[OP_DISP_CTRL]) begin
                        {mode_d.disp_on, mode_d.cursor_on, mode_d.blink_on} = lcd_data[2:0];
                    end else if (lcd_data[OP_ENTRY]) begin
                        {mode_d.inc_dec, mode_d.shift} = lcd_data[1:0];
                    end else if (lcd_data[OP_HOME]) begin
                        ac_d  = '0;
                        cnt_d = CBITS'(CLEAR_CYCLES);
                    end else if (lcd_data[OP_CLEAR]) begin
                        ac_d           = '0;
                        mode_d.inc_dec = 1'b1;
                        fill_d         = '0;
                        fill_active_d  = 1'b1;
                        cnt_d          = CBITS'(CLEAR_CYCLES);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = cnt_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= POWERUP;
            cnt_q         <= '0;
            e_q           <= 1'b0;
            ac_q          <= '0;
            fill_q        <= '0;
            fill_active_q <= 1'b0;
            mode_q        <= '0;
            init_done_q   <= 1'b0;
            proto_err_q   <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            e_q           <= e;
            ac_q          <= ac_d;
            fill_q        <= fill_d;
            fill_active_q <= fill_active_d;
            mode_q        <= mode_d;
            init_done_q   <= init_done_d;
            proto_err_q   <= proto_err_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign busy_flag = busy;
    assign ac        = ac_q;
    assign disp_on   = mode_q.disp_on;
    assign cursor_on = mode_q.cursor_on;
    assign blink_on  = mode_q.blink_on;
    assign inc_dec   = mode_q.inc_dec;
    assign shift     = mode_q.shift;
    assign two_line  = mode_q.two_line;
    assign font      = mode_q.font;
    assign init_done = init_done_q;
    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_lcd_responder.sv
// Bench for lcd_responder: bus-level stimulus, read data checked via a scoreboard queue.
module tb_lcd_responder;
    localparam int PU  = 500;
    localparam int CMD = 50;
    localparam int CLR = 200;

    logic       clk = 1'b0;
    logic       rst, e, rs, rw;
    logic [7:0] lcd_data;
    logic [6:0] dbg_addr;
    logic [7:0] rd_data, dbg_char;
    logic       rd_valid, busy_flag;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, inc_dec, shift, two_line, font;
    logic       init_done, proto_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic       rdv_prev = 1'b0;

    always #5 clk = ~clk;

    lcd_responder #(
        .POWERUP_CYCLES(PU),
        .CMD_CYCLES    (CMD),
        .CLEAR_CYCLES  (CLR),
        .DDRAM_DEPTH   (80),
        .CBITS         (9)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .e        (e),
        .rs       (rs),
        .rw       (rw),
        .lcd_data (lcd_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy_flag(busy_flag),
        .ac       (ac),
        .disp_on  (disp_on),
        .cursor_on(cursor_on),
        .blink_on (blink_on),
        .inc_dec  (inc_dec),
        .shift    (shift),
        .two_line (two_line),
        .font     (font),
        .init_done(init_done),
        .proto_err(proto_err),
        .dbg_addr (dbg_addr),
        .dbg_char (dbg_char)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every read-data beat pops the value pushed when the read was issued.
    always @(negedge clk) begin
        if (rd_valid && !rdv_prev) begin
            if (sb.size() == 0) check("sb_pop", sb.size(), 1);
            else                check("rd_data", rd_data, sb.pop_front());
        end
        rdv_prev = rd_valid;
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic bus_write(input logic r_s, input logic [7:0] d);
        @(posedge clk);
        #1 rs = r_s; rw = 1'b0; lcd_data = d; e = 1'b1;
        @(posedge clk);
        #1 e = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic r_s, input logic [7:0] exp);
        sb.push_back(exp);
        @(posedge clk);
        #1 rs = r_s; rw = 1'b1; e = 1'b1;
        check("rdv_pre", rd_valid, 0);
        @(posedge clk);
        #1 check("rdv_rise", rd_valid, 1);
        e = 1'b0;
        @(posedge clk);
        #1 check("rdv_fall", rd_valid, 0);
        rw = 1'b0;
    endtask

    task automatic expect_busy(input string tag, input int exp_n);
        int n;
        n = 0;
        while (busy_flag && n < 1000) begin
            @(posedge clk);
            #1 n++;
        end
        check(tag, n, exp_n);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy_flag && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        check(tag, busy_flag, 0);
    endtask

    task automatic check_cell(input string tag, input logic [6:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1 check(tag, dbg_char, exp);
    endtask

    initial begin
        int nb;
        e = 1'b0; rs = 1'b0; rw = 1'b0; lcd_data = '0; dbg_addr = '0;

        do_reset();
        check("rst_busy", busy_flag, 1);
        check("rst_ac", ac, 0);
        check("rst_mode", {disp_on, cursor_on, blink_on, inc_dec, shift, two_line, font}, 0);
        check("rst_init", init_done, 0);
        check("rst_perr", proto_err, 0);
        check("rst_rd", {rd_valid, rd_data}, 0);
        nb = 0;
        for (int k = 1; k < PU; k++) begin
            @(posedge clk);
            #1 if (busy_flag) nb++;
        end
        check("pu_busy", nb, PU - 1);
        @(posedge clk);
        #1 check("pu_done", busy_flag, 0);
        check("pu_perr", proto_err, 0);

        bus_write(0, 8'h38);
        check("fs_bits", {two_line, font, init_done}, 3'b101);
        expect_busy("fs_busy", CMD);
        bus_write(0, 8'h0C);
        check("dc_bits", {disp_on, cursor_on, blink_on}, 3'b100);
        expect_busy("dc_busy", CMD);
        bus_write(0, 8'h01);
        check("clr_ac", ac, 0);
        expect_busy("clr_busy", CLR);
        bus_write(0, 8'h06);
        check("em_bits", {inc_dec, shift}, 2'b10);
        expect_busy("em_busy", CMD);
        check("init_perr", proto_err, 0);
        for (int i = 0; i < 80; i++) check_cell("ddram_blank", 7'(i), 8'h20);

        bus_read(0, 8'h00);
        bus_write(0, 8'hCF);
        check("ac_set79", ac, 79);
        expect_busy("sa_busy", CMD);
        bus_write(1, 8'h41);
        check("ac_wrap_up", ac, 0);
        expect_busy("wr_busy", CMD);
        bus_write(1, 8'h41);
        expect_busy("wr_busy2", CMD);
        check("ac_after", ac, 1);
        check_cell("cell79", 7'd79, 8'h41);
        check_cell("cell0", 7'd0, 8'h41);
        bus_read(0, 8'h01);

        bus_write(0, 8'h01);
        repeat (8) @(posedge clk);
        bus_write(0, 8'h08);
        check("busy_wr_perr", proto_err, 1);
        check("busy_wr_disp", disp_on, 1);
        bus_read(0, 8'h80);
        wait_idle("clr2_idle", 300);
        check_cell("clr2_c0", 7'd0, 8'h20);
        check_cell("clr2_c79", 7'd79, 8'h20);

        bus_write(0, 8'h04);
        check("em_dec", inc_dec, 0);
        expect_busy("em2_busy", CMD);
        bus_write(1, 8'h55);
        check("ac_wrap_dn", ac, 79);
        expect_busy("wr3_busy", CMD);
        check_cell("cell0_55", 7'd0, 8'h55);
        bus_write(0, 8'hD0);
        check("ac_mod", ac, 0);
        expect_busy("sa2_busy", CMD);
        bus_read(1, 8'h55);
        check("rd_ac", ac, 79);
        expect_busy("rd_busy", CMD - 1);

        bus_write(0, 8'h02);
        check("home_ac", ac, 0);
        bus_read(1, 8'h00);
        wait_idle("home_idle", 300);

        bus_write(0, 8'h06);
        expect_busy("em3_busy", CMD);
        bus_write(0, 8'h88);
        check("ac_set8", ac, 8);
        expect_busy("sa3_busy", CMD);
        for (int i = 0; i < 4; i++) begin
            bus_write(1, 8'h41 + 8'(i));
            expect_busy("wr4_busy", CMD);
        end
        check("ac_12", ac, 12);
        bus_write(0, 8'h01);
        repeat (10) @(posedge clk);
        #1 do_reset();
        check_cell("abort_c8", 7'd8, 8'h20);
        check_cell("abort_c9", 7'd9, 8'h20);
        check_cell("abort_c10", 7'd10, 8'h43);
        check_cell("abort_c11", 7'd11, 8'h44);
        check("rst2_perr", proto_err, 0);
        check("rst2_ac", ac, 0);
        check("rst2_disp", disp_on, 0);

        bus_write(0, 8'h0C);
        check("pu_wr_perr", proto_err, 1);
        check("pu_wr_disp", disp_on, 0);
        wait_idle("pu2_idle", PU + 20);

        do_reset();
        wait_idle("pu3_idle", PU + 20);
        check("pu3_perr", proto_err, 0);
        bus_write(0, 8'h0C);
        check("preinit_perr", proto_err, 1);
        check("preinit_disp", disp_on, 1);
        expect_busy("preinit_busy", CMD);

        repeat (2) @(posedge clk);
        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_responder.md
Name: lcd_responder

Overview:
- Synthesizable, cycle-counted model of an HD44780-style character LCD panel: the device end of the parallel e/rs/rw/data bus that our LCD init/write controller drives.
- Decodes instruction and data writes, maintains DDRAM, address counter (AC) and display mode registers, and answers busy-flag and data reads.
- Enforces execution times and flags protocol violations.
- Used as the DUT-side partner in controller benches and for liveness/safety checks on the pair.

Parameters:
- POWERUP_CYCLES, 500, cycles after reset before the first instruction is legal
- CMD_CYCLES, 50, busy time for every instruction except clear/home, and for data read/write
- CLEAR_CYCLES, 200, busy time for clear display and return home
- DDRAM_DEPTH, 80, character cells; AC wraps modulo this value
- CBITS, 9, busy/power-up counter width; must hold max(POWERUP_CYCLES, CLEAR_CYCLES)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- e  in  1  enable strobe from controller
- rs  in  1  0 = instruction, 1 = data
- rw  in  1  0 = write, 1 = read
- lcd_data  in  8  write data/instruction from controller
- rd_data  out  8  read data returned to controller
- rd_valid  out  1  rd_data valid (bus-drive enable)
- busy_flag  out  1  device busy (power-up or executing)
- ac  out  7  address counter
- disp_on, cursor_on, blink_on  out  1 each  display control bits
- inc_dec, shift  out  1 each  entry mode bits
- two_line, font  out  1 each  function set N/F bits
- init_done  out  1  first function set accepted after power-up
- proto_err  out  1  sticky protocol-violation flag
- dbg_addr  in  7  debug DDRAM read address
- dbg_char  out  8  DDRAM[dbg_addr], combinational

Behaviour:
- Reset (sync, active-high): state POWERUP; cnt=0; ac=0; all mode bits 0; rd_data=0; rd_valid=0; init_done=0; proto_err=0; busy_flag=1. DDRAM is not cleared.
- Edge detection: e_q is registered e. A rise is e & ~e_q; a fall is ~e & e_q. rs, rw and lcd_data are sampled on the fall cycle.
- State POWERUP: busy_flag=1; cnt increments. At cnt == POWERUP_CYCLES-1, go to IDLE with cnt=0. Any write fall here sets proto_err and is ignored.
- State IDLE: busy_flag=0. A write fall executes the access and loads cnt, then goes to EXEC.
  - clear display or return home: cnt=CLEAR_CYCLES.
  - all other writes: cnt=CMD_CYCLES.
- State EXEC: busy_flag=1; cnt decrements. At cnt==1, go to IDLE next cycle. Busy therefore lasts exactly N cycles, starting the cycle after the fall.
- Write fall while busy (EXEC or POWERUP): ignored, proto_err=1.
- Instruction decode (rs=0, rw=0) uses the highest set bit:
  - 1xxxxxxx: ac = d[6:0] mod DDRAM_DEPTH.
  - 01xxxxxx: CGRAM address; accepted and busy, no other effect.
  - 001DNFxx: two_line=N, font=F, init_done=1. D is ignored (8-bit mode only).
  - 0001xxxx: cursor/display shift; accepted and busy, no other effect.
  - 00001DCB: disp_on, cursor_on, blink_on.
  - 000001IS: inc_dec=I, shift=S.
  - 0000001x: ac=0.
  - 00000001: DDRAM fill 8'h20 (one cell per cycle during EXEC), ac=0, inc_dec=1.
  - 00000000: no-op, no busy.
- Any instruction other than function set before init_done=1 sets proto_err but still executes.
- Data write (rs=1, rw=0): DDRAM[ac]=d, then AC update.
- AC update: ac+1 if inc_dec else ac-1. Wrap: 79 goes to 0; 0 goes to 79.
- Reads (rw=1) are evaluated on the rise:
  - Next cycle, rd_valid=1 and rd_data is registered as follows:
    - rs=0: {busy_flag, ac}. Legal while busy; no busy time.
    - rs=1: DDRAM[ac], then AC update and CMD_CYCLES busy. If busy at the rise, rd_data=8'h00 and proto_err=1.
  - rd_valid drops the cycle after the fall.
- Simultaneous rise and reset: reset wins.
- Reset mid-EXEC: aborts the clear fill; already-written cells remain.

Decomposition:
- Package lcd_pkg: state enum {POWERUP, IDLE, EXEC}; instruction opcode-bit constants; the blank character 8'h20; DDRAM_DEPTH. Share this package with the controller.
- One sub-module, lcd_ddram: DDRAM_DEPTH x 8, one sync write port, two async read ports (AC and dbg).

Test Plan:
- Reset, idle 499 cycles -> busy_flag=1 throughout. Cycle 500 -> busy_flag=0, proto_err=0.
- Function set 8'h38 after power-up -> two_line=1, font=0, init_done=1, busy exactly 50 cycles.
- Full init sequence: 38, 0C, 01, 06 with controller spacing (wait 50/50/200/100 cycles) -> disp_on=1, cursor_on=0, inc_dec=1, DDRAM all 8'h20, proto_err=0.
- Set ac 8'hCF (ac=79), write data 8'h41 twice -> DDRAM[79]=8'h41, DDRAM[0]=8'h41, ac=1.
- Write 8'h0C 10 cycles after a clear -> ignored, proto_err=1, disp_on unchanged. Busy-flag read (rs=0, rw=1) during clear -> rd_data[7]=1.
- Entry mode 8'h04, ac=0, data read (rs=1, rw=1) -> rd_data=DDRAM[0], ac=79, rd_valid high from rise+1 until fall+1.
